// File: rtl/seq_mult_pipe_hs.sv
// seq_mult_pipe_hs: radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// one multiplier bit per cycle, signed or unsigned per operation.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid / in_ready    operand handshake (in_a, in_b, in_signed)
//   abort                  cancel the operation in BUSY or DONE
//   out_valid / out_ready  result handshake (out_product)
//   busy                   high while iterating
module seq_mult_pipe_hs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            in_ready_nxt;
  logic            busy_nxt;
  logic            out_valid_nxt;

  logic [PW-1:0]   a_q;
  logic [PW-1:0]   acc_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]   cnt_q;
  logic            sgn_q;

  logic            accept;
  logic            last_iter;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_step;

  // State register; handshake/status outputs are registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Next-state logic; abort outranks the result handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_BUSY;
      S_BUSY: begin
        if (abort)                   state_nxt = S_IDLE;
        else if (cnt_q == CW'(1))    state_nxt = S_DONE;
      end
      S_DONE: begin
        if (abort)                   state_nxt = S_IDLE;
        else if (out_ready)          state_nxt = S_IDLE;
      end
      default:                       state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the flops show it next cycle.
  always_comb begin
    in_ready_nxt  = 1'b0;
    busy_nxt      = 1'b0;
    out_valid_nxt = 1'b0;
    case (state_nxt)
      S_IDLE:  in_ready_nxt  = 1'b1;
      S_BUSY:  busy_nxt      = 1'b1;
      S_DONE:  out_valid_nxt = 1'b1;
      default: in_ready_nxt  = 1'b1;
    endcase
  end

  // One iteration: the multiplier MSB carries weight -2^(WIDTH-1) in signed mode.
  always_comb begin
    accept    = (state == S_IDLE) && in_valid;
    last_iter = (cnt_q == CW'(1));
    addend    = b_q[0] ? a_q : '0;
    acc_step  = (sgn_q && last_iter) ? (acc_q - addend) : (acc_q + addend);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      out_product <= '0;
    end else if (accept) begin
      a_q   <= {{WIDTH{in_a[WIDTH-1] & in_signed}}, in_a};
      b_q   <= in_b;
      acc_q <= '0;
      cnt_q <= CW'(WIDTH);
      sgn_q <= in_signed;
    end else if ((state == S_BUSY) && !abort) begin
      acc_q <= acc_step;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - CW'(1);
      if (last_iter) out_product <= acc_step;
    end
  end

endmodule
